row_fifo_mc: RTL and testbench

ROW_FIFO_MC -- requirements
Module: row_fifo_mc

---
 rtl/row_fifo_mc.sv | 121 ++++++++++++
 tb/tb_row_fifo_mc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/row_fifo_mc.sv
// rtl/row_fifo_mc.sv - multi-channel first-word-fall-through FIFO
// Each channel has private storage, pointers and an occupancy counter; errors are sticky.
module row_fifo_mc #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int CHANNELS   = 4,
  parameter  int AFULL_LVL  = 12,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [CW-1:0]              wr_ch,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  input  logic [CW-1:0]              rd_ch,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  input  logic [CHANNELS-1:0]        flush,
  output logic [CHANNELS-1:0]        full,
  output logic [CHANNELS-1:0]        empty,
  output logic [CHANNELS-1:0]        almost_full,
  output logic [CHANNELS*(AW+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       ch_err
);

  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);
  localparam logic [CW:0] CH_LIM    = (CW+1)'(CHANNELS);

  logic [DATA_WIDTH-1:0] mem [CHANNELS][DEPTH];
  logic [AW-1:0]         rd_ptr [CHANNELS];
  logic [AW-1:0]         wr_ptr [CHANNELS];
  logic [AW:0]           cnt    [CHANNELS];

  logic                  wr_ch_ok;
  logic                  rd_ch_ok;
  logic [CW-1:0]         rd_idx;
  logic [CHANNELS-1:0]   wr_sel;
  logic [CHANNELS-1:0]   rd_sel;
  logic [CHANNELS-1:0]   push;
  logic [CHANNELS-1:0]   pop;
  logic                  ovf_hit;
  logic                  udf_hit;
  logic                  ch_hit;

  assign wr_ch_ok = ({1'b0, wr_ch} < CH_LIM);
  assign rd_ch_ok = ({1'b0, rd_ch} < CH_LIM);
  assign rd_idx   = rd_ch_ok ? rd_ch : '0;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_status
      assign full[g]                  = (cnt[g] == FULL_CNT);
      assign empty[g]                 = (cnt[g] == '0);
      assign almost_full[g]           = (cnt[g] >= AFULL_CNT);
      assign count[g*(AW+1) +: AW+1]  = cnt[g];
    end
  endgenerate

  assign rd_data  = mem[rd_idx][rd_ptr[rd_idx]];
  assign rd_valid = rd_ch_ok && !empty[rd_idx];

  // A full channel still accepts a write when it is popped in the same cycle.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    pop    = '0;
    push   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel[i] = wr_en && (wr_ch == CW'(i));
      rd_sel[i] = rd_en && (rd_ch == CW'(i));
      pop[i]    = rd_sel[i] && !empty[i];
      push[i]   = wr_sel[i] && (!full[i] || pop[i]);
    end
  end

  assign ovf_hit = |(wr_sel & full & ~pop);
  assign udf_hit = |(rd_sel & empty);
  assign ch_hit  = (wr_en && !wr_ch_ok) || (rd_en && !rd_ch_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ch_err    <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (flush[i]) begin
          rd_ptr[i] <= '0;
          wr_ptr[i] <= '0;
          cnt[i]    <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
          if (push[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
          else if (pop[i] && !push[i]) cnt[i] <= cnt[i] - 1'b1;
        end
      end
      overflow  <= overflow  | ovf_hit;
      underflow <= underflow | udf_hit;
      ch_err    <= ch_err    | ch_hit;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!reset && push[i] && !flush[i]) mem[i][wr_ptr[i]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_row_fifo_mc.sv
// tb/tb_row_fifo_mc.sv - scoreboard bench for row_fifo_mc
// Per-channel expected-data queues are filled on accepted writes and drained on pops.
module tb_row_fifo_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [1:0]  rd_ch;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  flush;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic [3:0]  almost_full;
  logic [19:0] count;
  logic        overflow;
  logic        underflow;
  logic        ch_err;

  logic        wr_en3;
  logic [1:0]  wr_ch3;
  logic [31:0] wr_data3;
  logic        rd_en3;
  logic [1:0]  rd_ch3;
  logic [31:0] rd_data3;
  logic        rd_valid3;
  logic [2:0]  flush3;
  logic [2:0]  full3;
  logic [2:0]  empty3;
  logic [2:0]  almost_full3;
  logic [14:0] count3;
  logic        overflow3;
  logic        underflow3;
  logic        ch_err3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q [4][$];
  logic        exp_ovf;
  logic        exp_udf;

  always #5 clk = ~clk;

  row_fifo_mc u_dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .full(full), .empty(empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow), .ch_err(ch_err)
  );

  row_fifo_mc #(.CHANNELS(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_data(wr_data3),
    .rd_en(rd_en3), .rd_ch(rd_ch3), .rd_data(rd_data3), .rd_valid(rd_valid3),
    .flush(flush3), .full(full3), .empty(empty3), .almost_full(almost_full3),
    .count(count3), .overflow(overflow3), .underflow(underflow3), .ch_err(ch_err3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status();
    logic [19:0] ec;
    logic [3:0]  ef, ee, ea;
    for (int i = 0; i < 4; i++) begin
      ec[i*5 +: 5] = 5'(q[i].size());
      ef[i] = (q[i].size() == 16);
      ee[i] = (q[i].size() == 0);
      ea[i] = (q[i].size() >= 12);
    end
    check("count", count, ec);
    check("full", full, ef);
    check("empty", empty, ee);
    check("almost_full", almost_full, ea);
    check("overflow", overflow, exp_ovf);
    check("underflow", underflow, exp_udf);
    check("ch_err", ch_err, 1'b0);
  endtask

  task automatic step(input logic we, input int wc, input logic [31:0] wd,
                      input logic re, input int rc, input logic [3:0] fl);
    logic do_pop, do_push;
    wr_en = we; wr_ch = 2'(wc); wr_data = wd;
    rd_en = re; rd_ch = 2'(rc); flush = fl;
    #1;
    check("rd_valid", rd_valid, q[rc].size() != 0);
    if (q[rc].size() != 0) check("rd_data", rd_data, q[rc][0]);
    do_pop  = re && (q[rc].size() != 0);
    do_push = we && ((q[wc].size() < 16) || (do_pop && rc == wc));
    if (we && !do_push) exp_ovf = 1'b1;
    if (re && !do_pop)  exp_udf = 1'b1;
    if (do_pop && !fl[rc])  void'(q[rc].pop_front());
    if (do_push && !fl[wc]) q[wc].push_back(wd);
    for (int i = 0; i < 4; i++) if (fl[i]) q[i].delete();
    @(posedge clk); #1;
    check_status();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b1; wr_ch = 2'd2; wr_data = 32'hDEAD;
    rd_en = 1'b1; rd_ch = 2'd0; flush = 4'b0100;
    @(posedge clk); #1;
    reset = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; flush = '0;
    for (int i = 0; i < 4; i++) q[i].delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    #1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check_status();
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    rd_en = 1'b0; rd_ch = '0; flush = '0;
    wr_en3 = 1'b0; wr_ch3 = '0; wr_data3 = '0; rd_en3 = 1'b0; rd_ch3 = '0; flush3 = '0;
    exp_ovf = 1'b0; exp_udf = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Fill channel 2 in order then drain it.
    for (int k = 0; k < 16; k++) step(1'b1, 2, 32'h100 + k, 1'b0, 2, 4'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 0, 32'h0, 1'b1, 2, 4'b0);

    // Channel 1 full: simultaneous write and pop keeps it full without overflow.
    for (int k = 0; k < 16; k++) step(1'b1, 1, $urandom, 1'b0, 1, 4'b0);
    step(1'b1, 1, 32'hAAAA, 1'b1, 1, 4'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 0, 32'h0, 1'b1, 1, 4'b0);

    // Channel 3 wrap: 8 in, 8 out, then 20 writes; write 17 overflows.
    for (int k = 0; k < 8; k++) step(1'b1, 3, 32'h300 + k, 1'b0, 3, 4'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 0, 32'h0, 1'b1, 3, 4'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 3, 32'h310 + k, 1'b0, 3, 4'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 0, 32'h0, 1'b1, 3, 4'b0);

    // Pop empty channel 0 while writing it: pop rejected, write lands.
    step(1'b1, 0, 32'h55, 1'b1, 0, 4'b0);
    check("udf_rd_data", rd_data, 32'h55);
    step(1'b0, 0, 32'h0, 1'b1, 0, 4'b0);

    // Independent channels, then flush channel 0 while writing it.
    for (int k = 0; k < 5; k++) step(1'b1, 1, 32'h1000 + k, 1'b0, 0, 4'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 0, 32'h2000 + k, 1'b1, 1, 4'b0);
    step(1'b1, 0, 32'h77, 1'b0, 0, 4'b0001);
    step(1'b1, 2, 32'h88, 1'b0, 1, 4'b0);
    do_reset();

    // Random traffic across all channels.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 9) < 4), int'($urandom_range(0, 3)),
           ($urandom_range(0, 29) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0);
    end
    do_reset();

    // Three-channel instance: out-of-range index is ignored and flagged.
    check("ch_err3_rst", ch_err3, 1'b0);
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_data3 = 32'h33;
    @(posedge clk); #1;
    check("ch_err3", ch_err3, 1'b1);
    check("count3_bad", count3, 15'h0);
    wr_ch3 = 2'd2; rd_en3 = 1'b1; rd_ch3 = 2'd3;
    @(posedge clk); #1;
    wr_en3 = 1'b0; rd_en3 = 1'b0;
    check("count3_ch2", count3, 15'h0400);
    check("underflow3", underflow3, 1'b0);
    rd_ch3 = 2'd2;
    #1;
    check("rd_data3", rd_data3, 32'h33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
